// File: rtl/reg_file_wr.sv
// Four-entry register file with write port, sequenced clear and a scanning read-select.
// A clear sweeps one register per cycle; the read-select either auto-scans or follows a hold address.
module reg_file_wr #(
    parameter int WID      = 4,
    parameter int SCAN_DIV = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           Wr_en,
    input  logic [1:0]     Wr_adrr,
    input  logic [WID-1:0] Wr_data,
    input  logic           Clr,
    input  logic           Scan_en,
    input  logic [1:0]     Hold_adrr,
    output logic [WID-1:0] Reg_3,
    output logic [WID-1:0] Reg_2,
    output logic [WID-1:0] Reg_1,
    output logic [WID-1:0] Reg_0,
    output logic [1:0]     Adrr,
    output logic           Wr_done,
    output logic           Busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);

    state_t         state_q;
    logic [1:0]     clr_ptr_q;
    logic [WID-1:0] regs_q [4];
    logic           wr_done_q;
    logic           busy_q;

    logic [7:0]     div_q, div_d;
    logic [1:0]     adrr_q, adrr_d;

    // regs_q is indexed by address, so address 00 is Reg_3.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            clr_ptr_q <= 2'b00;
            wr_done_q <= 1'b0;
            busy_q    <= 1'b0;
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
        end else begin
            wr_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Clr) begin
                        state_q   <= CLEAR;
                        clr_ptr_q <= 2'b00;
                        busy_q    <= 1'b1;
                    end else if (Wr_en) begin
                        regs_q[Wr_adrr] <= Wr_data;
                        wr_done_q       <= 1'b1;
                    end
                end
                CLEAR: begin
                    regs_q[clr_ptr_q] <= '0;
                    clr_ptr_q         <= clr_ptr_q + 2'd1;
                    if (clr_ptr_q == 2'b11) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        div_d  = div_q;
        adrr_d = adrr_q;
        if (Scan_en) begin
            if (div_q == DIV_LAST) begin
                div_d  = 8'd0;
                adrr_d = adrr_q + 2'd1;
            end else begin
                div_d = div_q + 8'd1;
            end
        end else begin
            div_d  = 8'd0;
            adrr_d = Hold_adrr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q  <= 8'd0;
            adrr_q <= 2'b00;
        end else begin
            div_q  <= div_d;
            adrr_q <= adrr_d;
        end
    end

    assign Reg_3   = regs_q[0];
    assign Reg_2   = regs_q[1];
    assign Reg_1   = regs_q[2];
    assign Reg_0   = regs_q[3];
    assign Adrr    = adrr_q;
    assign Wr_done = wr_done_q;
    assign Busy    = busy_q;

endmodule

// File: tb/tb_reg_file_wr.sv
// Bench for reg_file_wr: directed scenarios plus a randomized run against a cycle model.
// The model tracks registers by address and the clear as a count of cycles remaining.
module tb_reg_file_wr;
    localparam int WID      = 4;
    localparam int SCAN_DIV = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           Wr_en = 1'b0;
    logic [1:0]     Wr_adrr = 2'b00;
    logic [WID-1:0] Wr_data = '0;
    logic           Clr = 1'b0;
    logic           Scan_en = 1'b0;
    logic [1:0]     Hold_adrr = 2'b00;
    logic [WID-1:0] Reg_3, Reg_2, Reg_1, Reg_0;
    logic [1:0]     Adrr;
    logic           Wr_done, Busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WID-1:0] m_regs [4];
    int             m_clear_left = 0;
    logic           m_wr_done = 1'b0;
    logic [1:0]     m_adrr = 2'b00;
    int             m_div = 0;

    reg_file_wr #(.WID(WID), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .reset(reset), .Wr_en(Wr_en), .Wr_adrr(Wr_adrr), .Wr_data(Wr_data),
        .Clr(Clr), .Scan_en(Scan_en), .Hold_adrr(Hold_adrr),
        .Reg_3(Reg_3), .Reg_2(Reg_2), .Reg_1(Reg_1), .Reg_0(Reg_0),
        .Adrr(Adrr), .Wr_done(Wr_done), .Busy(Busy)
    );

    always #5 clk = ~clk;

    function automatic logic [WID-1:0] dut_reg(input int a);
        case (a)
            0:       return Reg_3;
            1:       return Reg_2;
            2:       return Reg_1;
            default: return Reg_0;
        endcase
    endfunction

    task automatic model_step();
        if (reset) begin
            for (int i = 0; i < 4; i++) m_regs[i] = '0;
            m_clear_left = 0;
            m_wr_done    = 1'b0;
            m_adrr       = 2'b00;
            m_div        = 0;
        end else begin
            m_wr_done = 1'b0;
            if (m_clear_left > 0) begin
                m_regs[4 - m_clear_left] = '0;
                m_clear_left--;
            end else if (Clr) begin
                m_clear_left = 4;
            end else if (Wr_en) begin
                m_regs[Wr_adrr] = Wr_data;
                m_wr_done       = 1'b1;
            end
            if (Scan_en) begin
                m_div++;
                if (m_div == SCAN_DIV) begin
                    m_div  = 0;
                    m_adrr = m_adrr + 2'd1;
                end
            end else begin
                m_div  = 0;
                m_adrr = Hold_adrr;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            n_checks++;
            if (dut_reg(a) !== '0) begin
                n_fail++;
                $display("FAIL reset_reg addr=%0d got=%h exp=0", a, dut_reg(a));
            end
        end
        n_checks++;
        if (Adrr !== 2'b00) begin n_fail++; $display("FAIL reset_adrr got=%b exp=00", Adrr); end
        n_checks++;
        if (Wr_done !== 1'b0) begin n_fail++; $display("FAIL reset_wr_done got=%b exp=0", Wr_done); end
        n_checks++;
        if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    endtask

    task automatic test_write();
        Wr_en = 1'b1; Wr_adrr = 2'b00; Wr_data = 4'hA;
        tick();
        n_checks++;
        if (Reg_3 !== 4'hA || Wr_done !== 1'b1) begin
            n_fail++; $display("FAIL write_a Reg_3=%h Wr_done=%b exp A/1", Reg_3, Wr_done);
        end
        Wr_adrr = 2'b11; Wr_data = 4'h5;
        tick();
        n_checks++;
        if (Reg_0 !== 4'h5 || Wr_done !== 1'b1) begin
            n_fail++; $display("FAIL write_b Reg_0=%h Wr_done=%b exp 5/1", Reg_0, Wr_done);
        end
        Wr_en = 1'b0;
        tick();
        n_checks++;
        if (Wr_done !== 1'b0 || Reg_2 !== 4'h0 || Reg_1 !== 4'h0 || Reg_3 !== 4'hA) begin
            n_fail++;
            $display("FAIL write_after Wr_done=%b Reg_2=%h Reg_1=%h Reg_3=%h exp 0/0/0/A",
                     Wr_done, Reg_2, Reg_1, Reg_3);
        end
    endtask

    task automatic test_clear();
        for (int a = 0; a < 4; a++) begin
            Wr_en = 1'b1; Wr_adrr = 2'(a); Wr_data = 4'hF;
            tick();
        end
        Wr_en = 1'b0;
        Clr   = 1'b1;
        tick();
        Clr = 1'b0;
        n_checks++;
        if (Busy !== 1'b1 || Wr_done !== 1'b0) begin
            n_fail++; $display("FAIL clear_start Busy=%b Wr_done=%b exp 1/0", Busy, Wr_done);
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_checks++;
            if (Busy !== (k < 4)) begin
                n_fail++; $display("FAIL clear_busy step=%0d got=%b exp=%b", k, Busy, (k < 4));
            end
            for (int a = 0; a < 4; a++) begin
                n_checks++;
                if (dut_reg(a) !== ((a < k) ? 4'h0 : 4'hF)) begin
                    n_fail++;
                    $display("FAIL clear_reg step=%0d addr=%0d got=%h exp=%h",
                             k, a, dut_reg(a), ((a < k) ? 4'h0 : 4'hF));
                end
            end
        end
    endtask

    task automatic test_clr_wins();
        Clr = 1'b1; Wr_en = 1'b1; Wr_adrr = 2'b01; Wr_data = 4'h7;
        tick();
        Clr = 1'b0;
        n_checks++;
        if (Wr_done !== 1'b0 || Busy !== 1'b1 || Reg_2 !== 4'h0) begin
            n_fail++;
            $display("FAIL clr_wins Wr_done=%b Busy=%b Reg_2=%h exp 0/1/0", Wr_done, Busy, Reg_2);
        end
        for (int k = 1; k <= 4; k++) begin
            Clr = (k == 2);
            tick();
            n_checks++;
            if (Wr_done !== 1'b0) begin
                n_fail++; $display("FAIL clr_hold_wr_done step=%0d got=%b exp=0", k, Wr_done);
            end
        end
        Clr = 1'b0; Wr_en = 1'b0;
        n_checks++;
        if (Reg_2 !== 4'h0 || Busy !== 1'b0) begin
            n_fail++; $display("FAIL clr_hold_end Reg_2=%h Busy=%b exp 0/0", Reg_2, Busy);
        end
    endtask

    task automatic test_reset_mid_clear();
        Wr_en = 1'b1; Wr_adrr = 2'b10; Wr_data = 4'hC;
        tick();
        Wr_en = 1'b0; Clr = 1'b1;
        tick();
        Clr = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (Busy !== 1'b0 || Reg_3 !== 4'h0 || Reg_2 !== 4'h0 || Reg_1 !== 4'h0 || Reg_0 !== 4'h0) begin
            n_fail++;
            $display("FAIL mid_reset Busy=%b regs=%h%h%h%h exp 0/0000", Busy, Reg_3, Reg_2, Reg_1, Reg_0);
        end
        tick();
        Wr_en = 1'b1; Wr_adrr = 2'b10; Wr_data = 4'h9;
        tick();
        Wr_en = 1'b0;
        n_checks++;
        if (Reg_1 !== 4'h9 || Wr_done !== 1'b1 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_write Reg_1=%h Wr_done=%b Busy=%b exp 9/1/0", Reg_1, Wr_done, Busy);
        end
    endtask

    task automatic test_scan();
        reset = 1'b1; Scan_en = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (Adrr !== 2'b00) begin n_fail++; $display("FAIL scan_reset got=%b exp=00", Adrr); end
        for (int i = 1; i <= 16; i++) begin
            tick();
            n_checks++;
            if (Adrr !== 2'((i / SCAN_DIV) % 4)) begin
                n_fail++; $display("FAIL scan_step cyc=%0d got=%b exp=%b", i, Adrr, 2'((i / SCAN_DIV) % 4));
            end
        end
        Scan_en = 1'b0; Hold_adrr = 2'b10;
        tick();
        n_checks++;
        if (Adrr !== 2'b10) begin n_fail++; $display("FAIL scan_hold got=%b exp=10", Adrr); end
        Scan_en = 1'b1;
        for (int i = 1; i <= SCAN_DIV; i++) begin
            tick();
            n_checks++;
            if (Adrr !== ((i == SCAN_DIV) ? 2'b11 : 2'b10)) begin
                n_fail++;
                $display("FAIL scan_restart cyc=%0d got=%b exp=%b", i, Adrr, ((i == SCAN_DIV) ? 2'b11 : 2'b10));
            end
        end
        Scan_en = 1'b0; Hold_adrr = 2'b00;
        tick();
    endtask

    task automatic test_random();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 300; c++) begin
            Wr_en     = 1'($urandom_range(0, 1));
            Wr_adrr   = 2'($urandom_range(0, 3));
            Wr_data   = 4'($urandom_range(0, 15));
            Clr       = ($urandom_range(0, 11) == 0);
            Hold_adrr = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) Scan_en = ~Scan_en;
            reset     = ($urandom_range(0, 59) == 0);
            tick();
            for (int a = 0; a < 4; a++) begin
                n_checks++;
                if (dut_reg(a) !== m_regs[a]) begin
                    n_fail++; $display("FAIL rand_reg cyc=%0d addr=%0d got=%h exp=%h", c, a, dut_reg(a), m_regs[a]);
                end
            end
            n_checks++;
            if (Adrr !== m_adrr) begin
                n_fail++; $display("FAIL rand_adrr cyc=%0d got=%b exp=%b", c, Adrr, m_adrr);
            end
            n_checks++;
            if (Wr_done !== m_wr_done) begin
                n_fail++; $display("FAIL rand_wr_done cyc=%0d got=%b exp=%b", c, Wr_done, m_wr_done);
            end
            n_checks++;
            if (Busy !== (m_clear_left > 0)) begin
                n_fail++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", c, Busy, (m_clear_left > 0));
            end
        end
        reset = 1'b0; Wr_en = 1'b0; Clr = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        test_reset();
        test_write();
        test_clear();
        test_clr_wins();
        test_reset_mid_clear();
        test_scan();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
